// File: rtl/mem_burst_controller.sv
// Word-to-byte burst bridge between a host port and a byte-serial PHY; read words appear one cycle after their last byte.
// Host requests stall while busy; writes are paced by a 2-entry word FIFO (wready); reads have no backpressure.
module mem_burst_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_rdy = (cnt_q != CNT_W'(DEPTH));
  assign pop_vld  = (cnt_q != '0);
  assign pop_dat  = mem_q[rptr_q];
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop & pop_vld;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_dat;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (do_pop) rptr_d = ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module mem_burst_controller #(
  parameter int  DATA_W  = 32,
  parameter int  ADDR_W  = 22,
  parameter int  MAX_LEN = 8,
  parameter int  TIMEOUT = 1024,
  localparam int BYTES   = DATA_W / 8,
  localparam int LEN_W   = $clog2(MAX_LEN),
  localparam int AB_W    = $clog2(BYTES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rvalid,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  input  logic                   phy_ready,
  output logic                   phy_rd,
  output logic                   phy_we,
  output logic                   phy_rend,
  output logic                   phy_wend,
  output logic [ADDR_W+AB_W-1:0] phy_a,
  input  logic [7:0]             phy_dout,
  input  logic                   phy_byte_available,
  output logic [7:0]             phy_din,
  input  logic                   phy_ready_for_next_byte
);
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = $clog2(MAX_LEN * BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int PA_W  = ADDR_W + AB_W;

  typedef enum logic [2:0] {IDLE, WAIT_PHY, START, XFER, FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BI_W-1:0]   bidx_q, bidx_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              avail_q, avail_d;
  logic              rfnb_q, rfnb_d;

  logic              strobe, last_byte, abort;
  logic              fifo_push_rdy, fifo_pop, fifo_flush, fifo_vld;
  logic [DATA_W-1:0] fifo_head;

  // A strobe counts once per rising edge of the PHY handshake relevant to the burst direction.
  assign strobe    = we_q ? (phy_ready_for_next_byte & ~rfnb_q) : (phy_byte_available & ~avail_q);
  assign last_byte = (bidx_q == BI_W'(BYTES - 1));

  assign busy   = (state_q != IDLE);
  assign wready = busy & we_q & fifo_push_rdy;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign phy_a  = PA_W'(addr_q) << AB_W;
  assign phy_din = (busy && we_q && fifo_vld) ?
                   8'(fifo_head >> (8 * (BYTES - 1 - int'(bidx_q)))) : 8'h00;

  mem_burst_fifo #(.W(DATA_W), .DEPTH(2)) u_wfifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (fifo_flush),
    .push_vld (wvalid & busy & we_q),
    .push_dat (wdata),
    .push_rdy (fifo_push_rdy),
    .pop      (fifo_pop),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    bidx_d     = bidx_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    avail_d    = phy_byte_available;
    rfnb_d     = phy_ready_for_next_byte;
    abort      = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    req_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    phy_rd     = 1'b0;
    phy_we     = 1'b0;
    phy_rend   = 1'b0;
    phy_wend   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          cnt_d   = (CNT_W'(req_len) + CNT_W'(1)) * CNT_W'(BYTES);
          state_d = WAIT_PHY;
        end
      end
      WAIT_PHY: begin
        // A write only starts once there is a word to send.
        if (phy_ready && (!we_q || fifo_vld)) state_d = START;
      end
      START: begin
        phy_rd  = ~we_q;
        phy_we  = we_q;
        tmo_d   = '0;
        bidx_d  = '0;
        asm_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        phy_rend = ~we_q && (cnt_q == CNT_W'(1));
        if (strobe) begin
          tmo_d = '0;
          if (we_q && !fifo_vld) begin
            abort = 1'b1;
          end else begin
            cnt_d  = cnt_q - CNT_W'(1);
            bidx_d = last_byte ? '0 : bidx_q + BI_W'(1);
            if (we_q) begin
              fifo_pop = last_byte;
            end else begin
              asm_d = (asm_q << 8) | DATA_W'(phy_dout);
              if (last_byte) begin
                rdata_d  = asm_d;
                rvalid_d = 1'b1;
              end
            end
            if (cnt_q == CNT_W'(1)) state_d = FINISH;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT)) abort = 1'b1;
        end
      end
      FINISH: begin
        done     = 1'b1;
        phy_rend = ~we_q;
        phy_wend = we_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      err        = 1'b1;
      phy_rend   = ~we_q;
      phy_wend   = we_q;
      fifo_flush = 1'b1;
      cnt_d      = '0;
      tmo_d      = '0;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      bidx_q   <= '0;
      asm_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      avail_q  <= 1'b0;
      rfnb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      bidx_q   <= bidx_d;
      asm_q    <= asm_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      avail_q  <= avail_d;
      rfnb_q   <= rfnb_d;
    end
  end
endmodule

// File: tb/tb_mem_burst_controller.sv
// Scoreboard bench for mem_burst_controller: directed bursts push expectations, a negedge monitor checks outputs.
module tb_mem_burst_controller;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [21:0] req_addr;
  logic [2:0]  req_len;
  logic [31:0] wdata, rdata;
  logic        wvalid, wready, rvalid, done, err, busy;
  logic        phy_ready, phy_rd, phy_we, phy_rend, phy_wend;
  logic [23:0] phy_a;
  logic [7:0]  phy_dout, phy_din;
  logic        phy_byte_available, phy_ready_for_next_byte;

  int checks = 0;
  int failures = 0;
  int rd_cyc = 0, we_cyc = 0, wend_cyc = 0;
  logic        prev_rfnb = 1'b0;
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_evt[$];   // 2'b10 = done, 2'b01 = err
  logic [7:0]  exp_din[$];

  always #5 clk = ~clk;

  mem_burst_controller #(.DATA_W(32), .ADDR_W(22), .MAX_LEN(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .done(done), .err(err), .busy(busy),
    .phy_ready(phy_ready), .phy_rd(phy_rd), .phy_we(phy_we),
    .phy_rend(phy_rend), .phy_wend(phy_wend), .phy_a(phy_a),
    .phy_dout(phy_dout), .phy_byte_available(phy_byte_available),
    .phy_din(phy_din), .phy_ready_for_next_byte(phy_ready_for_next_byte)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (exp_rd.size() == 0) check("rvalid_unexpected", rvalid, 0);
        else check("rdata", rdata, exp_rd.pop_front());
      end
      if (done || err) begin
        if (exp_evt.size() == 0) check("event_unexpected", {done, err}, 2'b00);
        else check("done_err", {done, err}, exp_evt.pop_front());
      end
      if (phy_ready_for_next_byte && !prev_rfnb && exp_din.size() > 0)
        check("phy_din", phy_din, exp_din.pop_front());
      if (phy_rd) rd_cyc++;
      if (phy_we) we_cyc++;
      if (phy_wend) wend_cyc++;
    end
    prev_rfnb = phy_ready_for_next_byte;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic we, input logic [21:0] a, input logic [2:0] len);
    req_we = we; req_addr = a; req_len = len; req_valid = 1'b1;
    @(negedge clk);
    check("req_ready", req_ready, 1);
    tick(1);
    req_valid = 1'b0;
    check("busy_after_req", busy, 1);
  endtask

  task automatic push_word(input logic [31:0] w);
    bit ok = 0;
    wdata = w; wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    tick(1);
    wvalid = 1'b0;
    check("wready_seen", ok, 1);
  endtask

  task automatic wait_start(input logic exp_we);
    bit seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (phy_rd || phy_we) begin seen = 1; break; end
    end
    check("start_seen", seen, 1);
    if (seen) check("start_kind", {phy_rd, phy_we}, exp_we ? 2'b01 : 2'b10);
    tick(1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    check("back_to_idle", busy, 0);
    tick(1);
  endtask

  task automatic rd_byte(input logic [7:0] b);
    phy_dout = b; phy_byte_available = 1'b1;
    tick(1);
    phy_byte_available = 1'b0;
    tick(1);
  endtask

  task automatic wr_byte();
    phy_ready_for_next_byte = 1'b1;
    tick(1);
    phy_ready_for_next_byte = 1'b0;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, base;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
    wdata = '0; wvalid = 0; phy_ready = 0; phy_dout = '0;
    phy_byte_available = 0; phy_ready_for_next_byte = 0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_strobes", {rvalid, done, err, phy_rd, phy_we, phy_rend, phy_wend, wready}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rdata", rdata, 0);
    check("post_rst_phy_a", phy_a, 0);

    // Read, one word, MSB-first assembly
    phy_ready = 1'b1;
    base = rd_cyc;
    issue_req(0, 22'h012345, 3'd0);
    check("phy_a_read", phy_a, 24'h048D14);
    wait_start(0);
    exp_rd.push_back(32'h12345678); exp_evt.push_back(2'b10);
    rd_byte(8'h12); rd_byte(8'h34);
    check("rend_early", phy_rend, 0);
    rd_byte(8'h56);
    check("rend_before_last", phy_rend, 1);
    rd_byte(8'h78);
    wait_idle();
    check("phy_rd_one_cycle", rd_cyc - base, 1);

    // Write, two words
    phy_ready = 1'b0;
    base = wend_cyc;
    issue_req(1, 22'h3FFFFF, 3'd1);
    push_word(32'hDEADBEEF); push_word(32'h01020304);
    check("wready_full", wready, 0);
    check("phy_a_write", phy_a, 24'hFFFFFC);
    phy_ready = 1'b1;
    wait_start(1);
    foreach (exp_din[i]) exp_din.delete();
    exp_din = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_evt.push_back(2'b10);
    repeat (8) wr_byte();
    wait_idle();
    check("wend_once", wend_cyc - base, 1);

    // Write underrun: second word never supplied
    phy_ready = 1'b0;
    base = wend_cyc;
    issue_req(1, 22'h000040, 3'd1);
    push_word(32'hCAFEF00D);
    phy_ready = 1'b1;
    wait_start(1);
    exp_din = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    repeat (4) wr_byte();
    exp_evt.push_back(2'b01);
    phy_ready_for_next_byte = 1'b1;
    @(negedge clk);
    check("underrun_err", err, 1);
    check("underrun_wend", phy_wend, 1);
    tick(1);
    phy_ready_for_next_byte = 1'b0;
    check("underrun_idle", busy, 0);
    check("underrun_wend_once", wend_cyc - base, 1);

    // Write timeout with buffered words left over; the flush must discard them
    phy_ready = 1'b0;
    issue_req(1, 22'h000077, 3'd1);
    push_word(32'h11111111); push_word(32'h22222222);
    phy_ready = 1'b1;
    wait_start(1);
    exp_din = '{8'h11};
    exp_evt.push_back(2'b01);
    wr_byte();
    wait_idle();
    base = we_cyc;
    issue_req(1, 22'h000055, 3'd0);
    tick(6);
    check("flushed_no_start", we_cyc - base, 0);
    check("flushed_waiting", busy, 1);
    push_word(32'h11223344);
    wait_start(1);
    exp_din = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_evt.push_back(2'b10);
    repeat (4) wr_byte();
    wait_idle();

    // Read timeout after two bytes
    issue_req(0, 22'h000100, 3'd0);
    wait_start(0);
    exp_evt.push_back(2'b01);
    rd_byte(8'hA1);
    phy_dout = 8'hA2; phy_byte_available = 1'b1;
    tick(1);
    phy_byte_available = 1'b0;
    k = 0;
    for (int n = 0; n < 3 * TMO; n++) begin
      @(negedge clk);
      k++;
      if (err) break;
    end
    check("timeout_cycles", k, TMO);
    check("timeout_rend", phy_rend, 1);
    tick(1);
    check("timeout_idle", busy, 0);

    // Level held high counts as a single byte
    issue_req(0, 22'h000200, 3'd0);
    wait_start(0);
    exp_rd.push_back(32'hAABBCCDD); exp_evt.push_back(2'b10);
    phy_dout = 8'hAA; phy_byte_available = 1'b1;
    tick(5);
    phy_byte_available = 1'b0;
    tick(1);
    check("held_still_busy", busy, 1);
    rd_byte(8'hBB); rd_byte(8'hCC); rd_byte(8'hDD);
    wait_idle();

    // Full-length read burst
    issue_req(0, 22'h2AAAAA, 3'd7);
    wait_start(0);
    for (int w = 0; w < 8; w++)
      exp_rd.push_back({8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)});
    exp_evt.push_back(2'b10);
    for (int b = 1; b <= 32; b++) begin
      if (b == 32) check("full_rend_last", phy_rend, 1);
      if (b == 31) check("full_rend_not_yet", phy_rend, 0);
      rd_byte(8'(b));
    end
    wait_idle();

    // Reset in the middle of a write burst
    phy_ready = 1'b0;
    base = wend_cyc;
    issue_req(1, 22'h000300, 3'd3);
    push_word(32'hA0A1A2A3); push_word(32'hB0B1B2B3);
    phy_ready = 1'b1;
    wait_start(1);
    exp_din = '{8'hA0, 8'hA1, 8'hA2};
    repeat (3) wr_byte();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_phy", {phy_we, phy_wend, wready}, 3'b000);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_no_wend", wend_cyc - base, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    issue_req(0, 22'h000010, 3'd1);
    wait_start(0);
    exp_rd.push_back(32'h01020304); exp_rd.push_back(32'h05060708);
    exp_evt.push_back(2'b10);
    for (int b = 1; b <= 8; b++) rd_byte(8'(b));
    wait_idle();

    tick(2);
    check("exp_rd_drained", exp_rd.size(), 0);
    check("exp_evt_drained", exp_evt.size(), 0);
    check("exp_din_drained", exp_din.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
